exec_unit: RTL and testbench

Execute stage of the 5-stage MIPS core. It consumes the decoded operation from the ID/EX pipeline register: ALU op, ALU result class, two 32-bit operands, destination register and write-enable. It produces a registered writeback record for the MEM stage. It owns the HI/LO register pair and a multi-cycle iterative divider, and raises a stall request upstream while a divide is in flight.

---
 rtl/exec_unit_pkg.sv | 57 +++++
 rtl/exec_unit_div_iter.sv | 114 +++++++++++
 rtl/exec_unit.sv | 174 +++++++++++++++++
 tb/tb_exec_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/exec_unit_pkg.sv
// Shared defines for the execute stage: bus widths, aluop/alusel codes and divider states.
// The divider is compiled in only when MIPSCPU_DIV_EN is defined.
package exec_unit_pkg;

  localparam int unsigned DataW    = 32;
  localparam int unsigned RegAddrW = 5;
  localparam int unsigned AluOpW   = 8;
  localparam int unsigned AluSelW  = 3;

  localparam logic [DataW-1:0] ZeroWord = '0;

  // Result classes
  localparam logic [AluSelW-1:0] SelNop     = 3'b000;
  localparam logic [AluSelW-1:0] SelLogic   = 3'b001;
  localparam logic [AluSelW-1:0] SelShift   = 3'b010;
  localparam logic [AluSelW-1:0] SelMove    = 3'b011;
  localparam logic [AluSelW-1:0] SelAdd     = 3'b100;
  localparam logic [AluSelW-1:0] SelMult    = 3'b101;
  localparam logic [AluSelW-1:0] SelCompare = 3'b110;
  localparam logic [AluSelW-1:0] SelDiv     = 3'b111;

  // Operation codes
  localparam logic [AluOpW-1:0] OpNop   = 8'b0000_0000;
  localparam logic [AluOpW-1:0] OpAnd   = 8'b0010_0100;
  localparam logic [AluOpW-1:0] OpOr    = 8'b0010_0101;
  localparam logic [AluOpW-1:0] OpXor   = 8'b0010_0110;
  localparam logic [AluOpW-1:0] OpNor   = 8'b0010_0111;
  localparam logic [AluOpW-1:0] OpSll   = 8'b0111_1100;
  localparam logic [AluOpW-1:0] OpSrl   = 8'b0000_0010;
  localparam logic [AluOpW-1:0] OpSra   = 8'b0000_0011;
  localparam logic [AluOpW-1:0] OpSlt   = 8'b0010_1010;
  localparam logic [AluOpW-1:0] OpSltu  = 8'b0010_1011;
  localparam logic [AluOpW-1:0] OpAdd   = 8'b0010_0000;
  localparam logic [AluOpW-1:0] OpAddu  = 8'b0010_0001;
  localparam logic [AluOpW-1:0] OpSub   = 8'b0010_0010;
  localparam logic [AluOpW-1:0] OpSubu  = 8'b0010_0011;
  localparam logic [AluOpW-1:0] OpMovz  = 8'b0000_1010;
  localparam logic [AluOpW-1:0] OpMovn  = 8'b0000_1011;
  localparam logic [AluOpW-1:0] OpMfhi  = 8'b0001_0000;
  localparam logic [AluOpW-1:0] OpMthi  = 8'b0001_0001;
  localparam logic [AluOpW-1:0] OpMflo  = 8'b0001_0010;
  localparam logic [AluOpW-1:0] OpMtlo  = 8'b0001_0011;
  localparam logic [AluOpW-1:0] OpMult  = 8'b0001_1000;
  localparam logic [AluOpW-1:0] OpMultu = 8'b0001_1001;
  localparam logic [AluOpW-1:0] OpDiv   = 8'b0001_1010;
  localparam logic [AluOpW-1:0] OpDivu  = 8'b0001_1011;

  // Divider FSM encodings
  localparam logic [1:0] DivIdle = 2'b00;
  localparam logic [1:0] DivBusy = 2'b01;
  localparam logic [1:0] DivDone = 2'b10;

  function automatic logic [DataW-1:0] abs32(input logic [DataW-1:0] v, input logic sgn);
    return (sgn && v[DataW-1]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/exec_unit_div_iter.sv
// Iterative 32-step restoring divider with IDLE/BUSY/DONE sequencing.
// Compiled only when MIPSCPU_DIV_EN is defined.
`ifdef MIPSCPU_DIV_EN
module div_iter
  import exec_unit_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [DataW-1:0] dividend_i,
  input  logic [DataW-1:0] divisor_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [DataW-1:0] quotient_o,
  output logic [DataW-1:0] remainder_o
);

  logic [1:0]       state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [DataW-1:0] quo_q, quo_d;
  logic [DataW-1:0] rem_q, rem_d;
  logic [DataW-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;

  logic [DataW:0]   shifted;
  logic             fits;
  logic [DataW-1:0] trial;

  // Partial remainder is always below the divisor, so the shifted value fits in 33 bits
  // and the restored difference fits in 32.
  assign shifted = {rem_q, quo_q[DataW-1]};
  assign fits    = shifted >= {1'b0, dvs_q};
  assign trial   = shifted[DataW-1:0] - dvs_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    case (state_q)
      DivIdle: begin
        if (start_i) begin
          cnt_d = 6'd0;
          if (divisor_i == ZeroWord) begin
            quo_d   = '1;
            rem_d   = dividend_i;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = DivDone;
          end else begin
            quo_d   = abs32(dividend_i, signed_i);
            rem_d   = ZeroWord;
            dvs_d   = abs32(divisor_i, signed_i);
            qneg_d  = signed_i & (dividend_i[DataW-1] ^ divisor_i[DataW-1]);
            rneg_d  = signed_i & dividend_i[DataW-1];
            state_d = DivBusy;
          end
        end
      end
      DivBusy: begin
        if (abort_i) begin
          cnt_d   = 6'd0;
          state_d = DivIdle;
        end else begin
          rem_d = fits ? trial : shifted[DataW-1:0];
          quo_d = {quo_q[DataW-2:0], fits};
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_d = DivDone;
        end
      end
      DivDone: begin
        cnt_d   = 6'd0;
        state_d = DivIdle;
      end
      default: begin
        cnt_d   = 6'd0;
        state_d = DivIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DivIdle;
      cnt_q   <= 6'd0;
      quo_q   <= ZeroWord;
      rem_q   <= ZeroWord;
      dvs_q   <= ZeroWord;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign busy_o      = (state_q == DivBusy);
  assign done_o      = (state_q == DivDone);
  assign quotient_o  = qneg_q ? (~quo_q + 32'd1) : quo_q;
  assign remainder_o = rneg_q ? (~rem_q + 32'd1) : rem_q;

endmodule
`endif

// File: rtl/exec_unit.sv
// MIPS execute stage: ALU result mux, HI/LO pair and registered writeback record.
// Defining MIPSCPU_DIV_EN adds the iterative divider and its upstream stall.
module exec_unit
  import exec_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [AluOpW-1:0]   aluop_i,
  input  logic [AluSelW-1:0]  alusel_i,
  input  logic [DataW-1:0]    reg1_i,
  input  logic [DataW-1:0]    reg2_i,
  input  logic [RegAddrW-1:0] wd_i,
  input  logic                wreg_i,
  output logic [RegAddrW-1:0] wd_o,
  output logic                wreg_o,
  output logic [DataW-1:0]    wdata_o,
  output logic [DataW-1:0]    hi_o,
  output logic [DataW-1:0]    lo_o,
  output logic                stall_req_o
);

  logic [DataW-1:0]    hi_q, lo_q, hi_nx, lo_nx;
  logic                hi_we, lo_we;
  logic [DataW-1:0]    res;
  logic                we_ok;
  logic [RegAddrW-1:0] wd_q;
  logic                wreg_q;
  logic [DataW-1:0]    wdata_q;

  logic [DataW-1:0]    sum_add, sum_sub;
  logic                ovf_add, ovf_sub;
  logic [2*DataW-1:0]  prod_s, prod_u;

  logic                div_done;
  logic [DataW-1:0]    div_quo, div_rem;

  assign sum_add = reg1_i + reg2_i;
  assign sum_sub = reg1_i - reg2_i;
  assign ovf_add = (reg1_i[DataW-1] == reg2_i[DataW-1]) && (sum_add[DataW-1] != reg1_i[DataW-1]);
  assign ovf_sub = (reg1_i[DataW-1] != reg2_i[DataW-1]) && (sum_sub[DataW-1] != reg1_i[DataW-1]);
  assign prod_s  = {{DataW{reg1_i[DataW-1]}}, reg1_i} * {{DataW{reg2_i[DataW-1]}}, reg2_i};
  assign prod_u  = {ZeroWord, reg1_i} * {ZeroWord, reg2_i};

`ifdef MIPSCPU_DIV_EN
  logic is_div, div_busy;

  assign is_div = (alusel_i == SelDiv) && ((aluop_i == OpDiv) || (aluop_i == OpDivu));

  // Abort only if the divide vanishes from the held inputs while iterating.
  div_iter u_div_iter (
    .clk_i       (clk),
    .rst_ni      (rst),
    .start_i     (is_div),
    .signed_i    (aluop_i == OpDiv),
    .dividend_i  (reg1_i),
    .divisor_i   (reg2_i),
    .abort_i     (div_busy & ~is_div),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  assign stall_req_o = rst & ((is_div & ~div_busy & ~div_done) | div_busy);
`else
  assign div_done    = 1'b0;
  assign div_quo     = ZeroWord;
  assign div_rem     = ZeroWord;
  assign stall_req_o = 1'b0;
`endif

  // Unknown codes fall through the defaults: no write, zero data.
  always_comb begin
    res   = ZeroWord;
    we_ok = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    hi_nx = hi_q;
    lo_nx = lo_q;
    case (alusel_i)
      SelLogic: begin
        we_ok = 1'b1;
        case (aluop_i)
          OpAnd:   res = reg1_i & reg2_i;
          OpOr:    res = reg1_i | reg2_i;
          OpXor:   res = reg1_i ^ reg2_i;
          OpNor:   res = ~(reg1_i | reg2_i);
          default: we_ok = 1'b0;
        endcase
      end
      SelShift: begin
        we_ok = 1'b1;
        case (aluop_i)
          OpSll:   res = reg2_i << reg1_i[4:0];
          OpSrl:   res = reg2_i >> reg1_i[4:0];
          OpSra:   res = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
          default: we_ok = 1'b0;
        endcase
      end
      SelCompare: begin
        we_ok = 1'b1;
        case (aluop_i)
          OpSlt:   res = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
          OpSltu:  res = {31'd0, reg1_i < reg2_i};
          default: we_ok = 1'b0;
        endcase
      end
      SelAdd: begin
        case (aluop_i)
          OpAdd:  begin res = sum_add; we_ok = ~ovf_add; end
          OpAddu: begin res = sum_add; we_ok = 1'b1;     end
          OpSub:  begin res = sum_sub; we_ok = ~ovf_sub; end
          OpSubu: begin res = sum_sub; we_ok = 1'b1;     end
          default: ;
        endcase
      end
      SelMove: begin
        case (aluop_i)
          OpMovz: begin res = reg1_i; we_ok = (reg2_i == ZeroWord); end
          OpMovn: begin res = reg1_i; we_ok = (reg2_i != ZeroWord); end
          OpMfhi: begin res = hi_q;   we_ok = 1'b1; end
          OpMflo: begin res = lo_q;   we_ok = 1'b1; end
          OpMthi: begin hi_we = 1'b1; hi_nx = reg1_i; end
          OpMtlo: begin lo_we = 1'b1; lo_nx = reg1_i; end
          default: ;
        endcase
      end
      SelMult: begin
        case (aluop_i)
          OpMult:  begin hi_we = 1'b1; lo_we = 1'b1; {hi_nx, lo_nx} = prod_s; end
          OpMultu: begin hi_we = 1'b1; lo_we = 1'b1; {hi_nx, lo_nx} = prod_u; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= ZeroWord;
      lo_q <= ZeroWord;
    end else if (div_done) begin
      hi_q <= div_rem;
      lo_q <= div_quo;
    end else if (!stall_req_o) begin
      if (hi_we) hi_q <= hi_nx;
      if (lo_we) lo_q <= lo_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      wdata_q <= ZeroWord;
    end else if (stall_req_o) begin
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      wdata_q <= ZeroWord;
    end else begin
      wd_q    <= wd_i;
      wreg_q  <= wreg_i & we_ok;
      wdata_q <= res;
    end
  end

  assign wd_o    = wd_q;
  assign wreg_o  = wreg_q;
  assign wdata_o = wdata_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit; divider expectations follow MIPSCPU_DIV_EN.
module tb_exec_unit;
  import exec_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i, reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o, hi_o, lo_o;
  logic        stall_req_o;

  always #5 clk = ~clk;

  exec_unit dut (
    .clk         (clk),
    .rst         (rst),
    .aluop_i     (aluop_i),
    .alusel_i    (alusel_i),
    .reg1_i      (reg1_i),
    .reg2_i      (reg2_i),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .stall_req_o (stall_req_o)
  );

  typedef struct {
    string       name;
    logic [4:0]  wd;
    logic        wr;
    logic [31:0] d;
    logic        chk_d;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          total  = 0;
  int          passed = 0;
  logic        tb_valid = 1'b0;
  logic        acc = 1'b0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;
  logic [4:0]  next_wd = 5'd1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  // An instruction is accepted on any edge where it is presented and no stall is raised.
  always @(posedge clk) acc <= tb_valid && !stall_req_o;

  always @(negedge clk) begin
    if (acc) begin
      if (sbq.size() == 0) begin
        total++;
        $display("FAIL unexpected_output: got an accepted op, want none pending");
      end else begin
        mon_e = sbq.pop_front();
        chk({mon_e.name, "_wd"}, {27'd0, wd_o}, {27'd0, mon_e.wd});
        chk({mon_e.name, "_wreg"}, {31'd0, wreg_o}, {31'd0, mon_e.wr});
        if (mon_e.chk_d) chk({mon_e.name, "_wdata"}, wdata_o, mon_e.d);
        chk({mon_e.name, "_hi"}, hi_o, mon_e.hi);
        chk({mon_e.name, "_lo"}, lo_o, mon_e.lo);
      end
    end
  end

  task automatic issue(input string nm, input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] r1, input logic [31:0] r2, input logic wr,
                       input logic [31:0] d, input logic chk_d, input int stall_exp);
    exp_t e;
    int   n;
    @(negedge clk);
    aluop_i  = op;
    alusel_i = sel;
    reg1_i   = r1;
    reg2_i   = r2;
    wd_i     = next_wd;
    wreg_i   = 1'b1;
    e.name   = nm;
    e.wd     = next_wd;
    e.wr     = wr;
    e.d      = d;
    e.chk_d  = chk_d;
    e.hi     = exp_hi;
    e.lo     = exp_lo;
    sbq.push_back(e);
    next_wd  = next_wd + 5'd1;
    tb_valid = 1'b1;
    n = 0;
    #1;
    while (stall_req_o && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk({nm, "_stall_cycles"}, 32'(n), 32'(stall_exp));
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    aluop_i = OpNop; alusel_i = SelNop; reg1_i = '0; reg2_i = '0; wd_i = '0; wreg_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wd", {27'd0, wd_o}, 32'd0);
    chk("rst_wreg", {31'd0, wreg_o}, 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    chk("rst_stall", {31'd0, stall_req_o}, 32'd0);
    rst = 1'b1;

    issue("addu_wrap", OpAddu, SelAdd, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 1'b1, 0);
    issue("add_ovf", OpAdd, SelAdd, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b0, 0);
    issue("add_ok", OpAdd, SelAdd, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'd1, 1'b1, 0);
    issue("sub_ovf", OpSub, SelAdd, 32'h8000_0000, 32'd1, 1'b0, 32'd0, 1'b0, 0);
    issue("subu", OpSubu, SelAdd, 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b1, 0);
    issue("and", OpAnd, SelLogic, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1, 32'h00F0_1234, 1'b1, 0);
    issue("or", OpOr, SelLogic, 32'h1234_0000, 32'h0000_5678, 1'b1, 32'h1234_5678, 1'b1, 0);
    issue("xor", OpXor, SelLogic, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1, 32'hF0F0_F0F0, 1'b1, 0);
    issue("nor", OpNor, SelLogic, 32'hF0F0_0000, 32'h0000_FFFF, 1'b1, 32'h0F0F_0000, 1'b1, 0);
    issue("lui", OpXor, SelLogic, 32'h1234_0000, 32'd0, 1'b1, 32'h1234_0000, 1'b1, 0);
    issue("sll", OpSll, SelShift, 32'd31, 32'd1, 1'b1, 32'h8000_0000, 1'b1, 0);
    issue("srl", OpSrl, SelShift, 32'd4, 32'h8000_0000, 1'b1, 32'h0800_0000, 1'b1, 0);
    issue("sra", OpSra, SelShift, 32'd4, 32'h8000_0000, 1'b1, 32'hF800_0000, 1'b1, 0);
    issue("sltu", OpSltu, SelCompare, 32'd1, 32'hFFFF_FFFF, 1'b1, 32'd1, 1'b1, 0);
    issue("slt", OpSlt, SelCompare, 32'd1, 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b1, 0);
    issue("movz_take", OpMovz, SelMove, 32'hAA, 32'd0, 1'b1, 32'hAA, 1'b1, 0);
    issue("movz_skip", OpMovz, SelMove, 32'hAA, 32'd1, 1'b0, 32'd0, 1'b0, 0);
    issue("movn_take", OpMovn, SelMove, 32'hBB, 32'd1, 1'b1, 32'hBB, 1'b1, 0);

    exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFFA;
    issue("mult", OpMult, SelMult, 32'hFFFF_FFFE, 32'd3, 1'b0, 32'd0, 1'b0, 0);
    issue("mflo", OpMflo, SelMove, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFA, 1'b1, 0);
    issue("mfhi", OpMfhi, SelMove, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 0);
    exp_hi = 32'hFFFF_FFFE; exp_lo = 32'h0000_0001;
    issue("multu", OpMultu, SelMult, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0, 0);
    exp_hi = 32'h1111;
    issue("mthi", OpMthi, SelMove, 32'h1111, 32'd0, 1'b0, 32'd0, 1'b0, 0);
    issue("mfhi_fwd", OpMfhi, SelMove, 32'd0, 32'd0, 1'b1, 32'h1111, 1'b1, 0);
    exp_lo = 32'h2222;
    issue("mtlo", OpMtlo, SelMove, 32'h2222, 32'd0, 1'b0, 32'd0, 1'b0, 0);
    issue("mflo_fwd", OpMflo, SelMove, 32'd0, 32'd0, 1'b1, 32'h2222, 1'b1, 0);

`ifdef MIPSCPU_DIV_EN
    exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFFD;
    issue("div_neg", OpDiv, SelDiv, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0, 1'b0, 33);
    exp_hi = 32'd2; exp_lo = 32'd14;
    issue("divu", OpDivu, SelDiv, 32'd100, 32'd7, 1'b0, 32'd0, 1'b0, 33);
    exp_hi = 32'd5; exp_lo = 32'hFFFF_FFFF;
    issue("divu_zero", OpDivu, SelDiv, 32'd5, 32'd0, 1'b0, 32'd0, 1'b0, 1);
`else
    issue("div_neg", OpDiv, SelDiv, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0, 1'b0, 0);
    issue("divu", OpDivu, SelDiv, 32'd100, 32'd7, 1'b0, 32'd0, 1'b0, 0);
    issue("divu_zero", OpDivu, SelDiv, 32'd5, 32'd0, 1'b0, 32'd0, 1'b0, 0);
`endif
    issue("mflo_div", OpMflo, SelMove, 32'd0, 32'd0, 1'b1, exp_lo, 1'b1, 0);
    issue("mfhi_div", OpMfhi, SelMove, 32'd0, 32'd0, 1'b1, exp_hi, 1'b1, 0);
    issue("unknown", 8'hFF, SelLogic, 32'h1234, 32'h5678, 1'b0, 32'd0, 1'b1, 0);

    // Reset in the middle of a divide
    @(negedge clk);
    tb_valid = 1'b0;
    aluop_i = OpDivu; alusel_i = SelDiv; reg1_i = 32'd100; reg2_i = 32'd7;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_wd", {27'd0, wd_o}, 32'd0);
    chk("abort_wreg", {31'd0, wreg_o}, 32'd0);
    chk("abort_wdata", wdata_o, 32'd0);
    chk("abort_hi", hi_o, 32'd0);
    chk("abort_lo", lo_o, 32'd0);
    chk("abort_stall", {31'd0, stall_req_o}, 32'd0);
    aluop_i = OpOr; alusel_i = SelLogic; reg1_i = 32'd0; reg2_i = 32'h1234;
    @(negedge clk);
    rst = 1'b1;
    exp_hi = 32'd0; exp_lo = 32'd0;
    issue("ori_after_rst", OpOr, SelLogic, 32'd0, 32'h1234, 1'b1, 32'h1234, 1'b1, 0);
    issue("mfhi_after_rst", OpMfhi, SelMove, 32'd0, 32'd0, 1'b1, 32'd0, 1'b1, 0);

    @(negedge clk);
    tb_valid = 1'b0;
    aluop_i = OpNop; alusel_i = SelNop;
    repeat (2) @(negedge clk);
    chk("drain", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
